// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and the bit-level state encoding used by
//                the UART receive and transmit paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 12 MHz board clock divided down to 115200 baud.
    localparam int B115200              = 104;
    localparam int CLKS_PER_BIT_DEFAULT = B115200;

    // Frame phase shared by the RX and TX bit engines.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_instruction_link_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_instruction_link_if
//  Description : Host-side signal bundle of the instruction link: serial lines,
//                assembled instruction strobe and transmit byte handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_instruction_link_if;
    logic        rx;
    logic [31:0] instruction;
    logic        instruction_rcv;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx;
    logic        tx_ready;

    // Host / harness side.
    modport master (
        output rx, tx_data, tx_start,
        input  instruction, instruction_rcv, tx, tx_ready
    );

    // Link side.
    modport slave (
        input  rx, tx_data, tx_start,
        output instruction, instruction_rcv, tx, tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 byte receiver. Synchronises the raw line, samples at bit
//                centres and reports a good byte (valid) or a bad stop bit
//                (frame_err) as single-cycle pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  wire logic       clk12,
    input  wire logic       rst,
    input  wire logic       rx,
    output logic [7:0]      data,
    output logic            valid,
    output logic            frame_err
);
    localparam int              c_CW        = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_LAST      = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q;
    uart_state_e     state_q, state_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            wait_high_q, wait_high_d;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Bit engine state registers.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            wait_high_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            wait_high_q <= wait_high_d;
        end
    end

    // Next-state: half-bit to the start centre, then full bits to each centre.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        wait_high_d = wait_high_q;
        valid       = 1'b0;
        frame_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // After a framing error the line must return high before re-arming.
                if (wait_high_q) begin
                    if (sync2_q) wait_high_d = 1'b0;
                end else if (!sync2_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == c_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == c_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync2_q) begin
                        valid = 1'b1;
                    end else begin
                        frame_err   = 1'b1;
                        wait_high_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data = shreg_q;

endmodule
`default_nettype wire

// File: rtl/uart_instruction_link.sv
`default_nettype none
// ============================================================================
//  Module      : uart_instruction_link
//  Description : Host serial link. Assembles four received bytes into a 32-bit
//                instruction with a one-cycle strobe, and transmits single
//                bytes with a ready/start handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_instruction_link
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  wire logic              clk12,
    input  wire logic              rst,
    uart_instruction_link_if.slave bus
);
    localparam int              c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_BIT - 1);

    // ---------------- receive path ----------------
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [23:0] lanes_q, lanes_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] instruction_q, instruction_d;
    logic        instruction_rcv_q, instruction_rcv_d;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk12     (clk12),
        .rst       (rst),
        .rx        (bus.rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_err)
    );

    // Word assembly registers; the published word only changes on a full word.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            lanes_q           <= '0;
            byte_cnt_q        <= '0;
            instruction_q     <= '0;
            instruction_rcv_q <= 1'b0;
        end else begin
            lanes_q           <= lanes_d;
            byte_cnt_q        <= byte_cnt_d;
            instruction_q     <= instruction_d;
            instruction_rcv_q <= instruction_rcv_d;
        end
    end

    // Lane steering: bytes 0..2 are staged, byte 3 publishes the whole word.
    always_comb begin
        lanes_d           = lanes_q;
        byte_cnt_d        = byte_cnt_q;
        instruction_d     = instruction_q;
        instruction_rcv_d = 1'b0;
        if (rx_err) begin
            byte_cnt_d = '0;
        end else if (rx_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    lanes_d[7:0]   = rx_data;
                2'd1:    lanes_d[15:8]  = rx_data;
                2'd2:    lanes_d[23:16] = rx_data;
                default: begin
                    instruction_d     = {rx_data, lanes_q};
                    instruction_rcv_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.instruction     = instruction_q;
    assign bus.instruction_rcv = instruction_rcv_q;

    // ---------------- transmit path ----------------
    uart_state_e     tx_state_q, tx_state_d;
    logic [c_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shreg_q, tx_shreg_d;
    logic            tx_q, tx_d;
    logic            tx_ready_q, tx_ready_d;

    // Transmit state registers; the line idles high and ready after reset.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // Next line level is computed one bit ahead so tx comes straight off a flop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        unique case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (bus.tx_start) begin
                    tx_shreg_d = bus.tx_data;
                    tx_state_d = START;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            START: begin
                if (tx_cnt_q == c_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shreg_q[0];
                    tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_cnt_q == c_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shreg_q[0];
                        tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (tx_cnt_q == c_LAST) begin
                    tx_cnt_d   = '0;
                    tx_ready_d = 1'b1;
                    tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = tx_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_instruction_link.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_instruction_link
//  Description : Directed bench for the instruction link: idle/reset values,
//                word assembly, framing error, glitch rejection, byte transmit
//                and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_instruction_link;
    localparam int c_CPB = 104;

    logic clk12 = 1'b0;
    logic rst   = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   pulse_cnt = 0;
    int   pulse_cyc = 0;
    int   stop_start = 0;
    logic [31:0] last_word = '0;

    uart_instruction_link_if bus_if ();

    uart_instruction_link #(.CLKS_PER_BIT(c_CPB)) dut (
        .clk12 (clk12),
        .rst   (rst),
        .bus   (bus_if)
    );

    always #5 clk12 = ~clk12;

    always @(posedge clk12) cyc <= cyc + 1;

    // Record every instruction strobe away from the active edge.
    always @(negedge clk12) begin
        if (bus_if.instruction_rcv) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
            last_word = bus_if.instruction;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame on rx; stop_bit=0 produces a framing error.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus_if.rx = 1'b0;
        repeat (c_CPB) @(negedge clk12);
        for (int i = 0; i < 8; i++) begin
            bus_if.rx = b[i];
            repeat (c_CPB) @(negedge clk12);
        end
        stop_start = cyc;
        bus_if.rx = stop_bit;
        repeat (c_CPB) @(negedge clk12);
        bus_if.rx = 1'b1;
        repeat (20) @(negedge clk12);
    endtask

    initial begin
        int          p0;
        int          lat;
        logic [9:0]  line;

        bus_if.rx       = 1'b1;
        bus_if.tx_start = 1'b0;
        bus_if.tx_data  = 8'h00;

        // ---- 1: reset values and long idle ----
        repeat (3) @(negedge clk12);
        check("rst_tx", {31'd0, bus_if.tx}, 32'd1);
        check("rst_tx_ready", {31'd0, bus_if.tx_ready}, 32'd1);
        check("rst_instr", bus_if.instruction, 32'h0);
        check("rst_rcv", {31'd0, bus_if.instruction_rcv}, 32'd0);
        rst = 1'b0;
        repeat (2000) @(negedge clk12);
        check("idle_tx", {31'd0, bus_if.tx}, 32'd1);
        check("idle_tx_ready", {31'd0, bus_if.tx_ready}, 32'd1);
        check("idle_instr", bus_if.instruction, 32'h0);
        check("idle_no_pulse", pulse_cnt, 0);

        // ---- 2: one word ----
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hA0, 1'b1);
        check("partial_hidden", bus_if.instruction, 32'h0);
        send_byte(8'h00, 1'b1);
        check("w1_pulses", pulse_cnt, 1);
        check("w1_word", last_word, 32'h00A00513);
        lat = pulse_cyc - stop_start;
        check("w1_at_stop_centre", {31'd0, (lat >= 50 && lat <= 60)}, 32'd1);
        check("w1_hold", bus_if.instruction, 32'h00A00513);

        // ---- 3: framing error discards the partial word ----
        p0 = pulse_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h55, 1'b0);
        check("ferr_hold", bus_if.instruction, 32'h00A00513);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        check("w2_pulses", pulse_cnt - p0, 1);
        check("w2_word", last_word, 32'h12345678);

        // ---- 4: short low glitch is rejected ----
        p0 = pulse_cnt;
        bus_if.rx = 1'b0;
        repeat (20) @(negedge clk12);
        bus_if.rx = 1'b1;
        repeat (300) @(negedge clk12);
        check("glitch_no_pulse", pulse_cnt - p0, 0);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        check("w3_pulses", pulse_cnt - p0, 1);
        check("w3_word", last_word, 32'hEFBEADDE);
        check("w3_instr", bus_if.instruction, 32'hEFBEADDE);

        // ---- 5: single byte transmit ----
        line = {1'b1, 8'hA5, 1'b0};
        bus_if.tx_data  = 8'hA5;
        bus_if.tx_start = 1'b1;
        @(negedge clk12);
        bus_if.tx_start = 1'b0;
        check("tx5_ready_low", {31'd0, bus_if.tx_ready}, 32'd0);
        for (int n = 1; n <= 1040; n++) begin
            @(negedge clk12);
            if (n >= 52 && (n - 52) % c_CPB == 0)
                check($sformatf("tx5_bit%0d", (n - 52) / c_CPB), {31'd0, bus_if.tx},
                      {31'd0, line[(n - 52) / c_CPB]});
            if (n == 1039) check("tx5_busy_end", {31'd0, bus_if.tx_ready}, 32'd0);
            if (n == 1040) check("tx5_ready_back", {31'd0, bus_if.tx_ready}, 32'd1);
        end
        repeat (10) @(negedge clk12);

        // ---- 6: held start, mid-frame data change, back-to-back, reset ----
        line = {1'b1, 8'h81, 1'b0};
        bus_if.tx_data  = 8'h81;
        bus_if.tx_start = 1'b1;
        @(negedge clk12);
        check("tx6_ready_low", {31'd0, bus_if.tx_ready}, 32'd0);
        for (int n = 1; n <= 1405; n++) begin
            @(negedge clk12);
            if (n == 200) bus_if.tx_data = 8'h3C;
            if (n >= 52 && n <= 988 && (n - 52) % c_CPB == 0)
                check($sformatf("tx6_bit%0d", (n - 52) / c_CPB), {31'd0, bus_if.tx},
                      {31'd0, line[(n - 52) / c_CPB]});
            if (n == 600) check("tx6_busy_ignore", {31'd0, bus_if.tx_ready}, 32'd0);
            if (n == 1040) check("tx6_ready_gap", {31'd0, bus_if.tx_ready}, 32'd1);
            if (n == 1041) begin
                check("tx6_b2b_ready", {31'd0, bus_if.tx_ready}, 32'd0);
                check("tx6_b2b_start", {31'd0, bus_if.tx}, 32'd0);
            end
            if (n == 1301) check("tx6_f2_bit1", {31'd0, bus_if.tx}, 32'd0);
            if (n == 1405) check("tx6_f2_bit2", {31'd0, bus_if.tx}, 32'd1);
        end
        bus_if.tx_start = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_tx", {31'd0, bus_if.tx}, 32'd1);
        check("rst_mid_ready", {31'd0, bus_if.tx_ready}, 32'd1);
        check("rst_mid_instr", bus_if.instruction, 32'h0);
        repeat (3) @(negedge clk12);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
